// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types: cache line and memory-arbiter FSM states.
package lc3b_types;
  localparam int LINE_BITS = 128;

  typedef logic [LINE_BITS-1:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } arb_state_t;
endpackage

// File: rtl/arb_pick.sv
// Winner select between icache and dcache miss requests.
// ARB_RR_EN: round-robin on contention; otherwise dcache has fixed priority.
module arb_pick (
  input  logic i_req,
  input  logic d_req,
  input  logic last_grant,  // 1 = dcache was granted last
  output logic pick_d
);
`ifdef ARB_RR_EN
  always_comb begin
    if (i_req && d_req) pick_d = ~last_grant;
    else                pick_d = d_req;
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  // dcache serves the older instruction sitting in MEM, so it wins ties
  always_comb begin
    if (i_req && d_req) pick_d = 1'b1;
    else                pick_d = d_req;
  end
`endif
endmodule

// File: rtl/mem_arbiter.sv
// Shares the pmem line port between icache and dcache miss paths, one
// transaction at a time. Arbitration policy selected by ARB_RR_EN.
module mem_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);
  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              write_q;
  logic              last_grant;
  logic              pick_d;
  logic              req_any;
  logic              grant;

  assign req_any = i_read | d_read | d_write;
  assign grant   = (state_q == IDLE) && req_any;

`ifdef ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last_grant <= 1'b0;
    else if (grant) last_grant <= pick_d;
  end
`else
  assign last_grant = 1'b0;
`endif

  arb_pick u_pick (
    .i_req      (i_read),
    .d_req      (d_read | d_write),
    .last_grant (last_grant),
    .pick_d     (pick_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Requester inputs are only sampled at grant; SERVE runs off these latches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else if (grant) begin
      addr_q  <= pick_d ? d_addr : i_addr;
      wdata_q <= pick_d ? d_wdata : '0;
      write_q <= pick_d & d_write;
    end
  end

  always_comb begin
    state_d    = state_q;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    i_rdata    = '0;
    d_rdata    = '0;
    case (state_q)
      IDLE: begin
        if (req_any) state_d = pick_d ? SERVE_D : SERVE_I;
      end
      SERVE_I: begin
        pmem_read  = ~write_q;
        pmem_write = write_q;
        if (pmem_resp) begin
          i_resp  = 1'b1;
          i_rdata = pmem_rdata;
          state_d = DONE;
        end
      end
      SERVE_D: begin
        pmem_read  = ~write_q;
        pmem_write = write_q;
        if (pmem_resp) begin
          d_resp  = 1'b1;
          d_rdata = write_q ? '0 : pmem_rdata;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign pmem_addr  = addr_q;
  assign pmem_wdata = wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; expectations follow ARB_RR_EN when defined.
module tb_mem_arbiter;
  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;

  logic              clk;
  logic              rst_n;
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_addr;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  int total;
  int bad;

  localparam logic [LINE_W-1:0] L_DB = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
  localparam logic [LINE_W-1:0] L_A  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [LINE_W-1:0] L_B  = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;
  localparam logic [LINE_W-1:0] L_5  = 128'h5555_5555_5555_5555_5555_5555_5555_5555;
  localparam logic [LINE_W-1:0] L_AA = 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA;

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_read     (i_read),
    .i_addr     (i_addr),
    .i_rdata    (i_rdata),
    .i_resp     (i_resp),
    .d_read     (d_read),
    .d_write    (d_write),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_resp     (d_resp),
    .pmem_read  (pmem_read),
    .pmem_write (pmem_write),
    .pmem_addr  (pmem_addr),
    .pmem_wdata (pmem_wdata),
    .pmem_rdata (pmem_rdata),
    .pmem_resp  (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in IDLE with requests already driven; zero-latency memory.
  task automatic xact(input string tag, input logic exp_d,
                      input logic [ADDR_W-1:0] exp_addr, input logic [LINE_W-1:0] rd);
    tick();
    chk({tag, ".strobe"}, {127'd0, pmem_read}, 128'd1);
    chk({tag, ".addr"}, {112'd0, pmem_addr}, {112'd0, exp_addr});
    pmem_rdata = rd;
    pmem_resp  = 1'b1;
    #1;
    chk({tag, ".i_resp"}, {127'd0, i_resp}, {127'd0, ~exp_d});
    chk({tag, ".d_resp"}, {127'd0, d_resp}, {127'd0, exp_d});
    chk({tag, ".rdata"}, exp_d ? d_rdata : i_rdata, rd);
    tick();
    pmem_resp = 1'b0;
    #1;
    chk({tag, ".done_strobe"}, {126'd0, pmem_read, pmem_write}, 128'd0);
    chk({tag, ".done_resp"}, {126'd0, i_resp, d_resp}, 128'd0);
    tick();
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0;
    i_read = 1'b0; i_addr = '0;
    d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;

    #12;
    chk("reset.strobes", {126'd0, pmem_read, pmem_write}, 128'd0);
    chk("reset.resps", {126'd0, i_resp, d_resp}, 128'd0);
    chk("reset.addr", {112'd0, pmem_addr}, 128'd0);
    tick();
    rst_n = 1'b1;

    // lone icache read, memory answers in the 4th strobe cycle
    i_read = 1'b1; i_addr = 16'h1230;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("iread.strobe", {127'd0, pmem_read}, 128'd1);
      chk("iread.addr", {112'd0, pmem_addr}, 128'h1230);
      chk("iread.early_resp", {126'd0, i_resp, d_resp}, 128'd0);
      tick();
    end
    pmem_rdata = L_DB; pmem_resp = 1'b1;
    #1;
    chk("iread.last_strobe", {127'd0, pmem_read}, 128'd1);
    chk("iread.i_resp", {127'd0, i_resp}, 128'd1);
    chk("iread.i_rdata", i_rdata, L_DB);
    chk("iread.d_resp", {127'd0, d_resp}, 128'd0);
    chk("iread.d_rdata", d_rdata, 128'd0);
    i_read = 1'b0;
    tick();
    pmem_resp = 1'b0;
    #1;
    chk("iread.done_strobe", {127'd0, pmem_read}, 128'd0);
    chk("iread.done_resp", {127'd0, i_resp}, 128'd0);
    tick();

    // contention: dcache wins first in both builds
    i_read = 1'b1; i_addr = 16'h0100;
    d_read = 1'b1; d_addr = 16'h4000;
`ifdef ARB_RR_EN
    xact("rr0_d", 1'b1, 16'h4000, L_A);
    xact("rr1_i", 1'b0, 16'h0100, L_B);
    xact("rr2_d", 1'b1, 16'h4000, L_A);
    xact("rr3_i", 1'b0, 16'h0100, L_B);
    i_read = 1'b0; d_read = 1'b0;
`else
    xact("fp0_d", 1'b1, 16'h4000, L_A);
    d_read = 1'b0;
    xact("fp1_i", 1'b0, 16'h0100, L_B);
    i_read = 1'b0;
`endif
    tick();
    chk("contend.idle", {126'd0, pmem_read, pmem_write}, 128'd0);

    // dcache writeback, address changes mid-serve
    d_write = 1'b1; d_addr = 16'h2000; d_wdata = L_5;
    tick();
    chk("wr.pmem_write", {127'd0, pmem_write}, 128'd1);
    chk("wr.pmem_read", {127'd0, pmem_read}, 128'd0);
    chk("wr.addr", {112'd0, pmem_addr}, 128'h2000);
    chk("wr.wdata", pmem_wdata, L_5);
    d_addr = 16'hFFFF;
    tick();
    chk("wr.addr_latched", {112'd0, pmem_addr}, 128'h2000);
    chk("wr.still_write", {127'd0, pmem_write}, 128'd1);
    pmem_rdata = L_AA; pmem_resp = 1'b1;
    #1;
    chk("wr.d_resp", {127'd0, d_resp}, 128'd1);
    chk("wr.d_rdata_zero", d_rdata, 128'd0);
    chk("wr.i_resp", {127'd0, i_resp}, 128'd0);
    tick();
    // pmem_resp held into DONE, d_write still high: no resp, no strobe
    chk("wr.done_resp", {127'd0, d_resp}, 128'd0);
    chk("wr.done_strobe", {126'd0, pmem_read, pmem_write}, 128'd0);
    pmem_resp = 1'b0;
    tick();
    chk("wr.idle_strobe", {126'd0, pmem_read, pmem_write}, 128'd0);
    d_write = 1'b0;
    tick();
    chk("wr.no_regrant", {126'd0, pmem_read, pmem_write}, 128'd0);

    // stray pmem_resp in IDLE
    pmem_resp = 1'b1;
    #1;
    chk("idle_resp.resps", {126'd0, i_resp, d_resp}, 128'd0);
    tick();
    pmem_resp = 1'b0;
    chk("idle_resp.strobe", {126'd0, pmem_read, pmem_write}, 128'd0);

    // reset in the middle of a write transaction
    d_write = 1'b1; d_addr = 16'h3000; d_wdata = L_5;
    tick();
    chk("rst_mid.pre_write", {127'd0, pmem_write}, 128'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid.strobes", {126'd0, pmem_read, pmem_write}, 128'd0);
    chk("rst_mid.addr", {112'd0, pmem_addr}, 128'd0);
    chk("rst_mid.wdata", pmem_wdata, 128'd0);
    d_write = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("rst_mid.after", {126'd0, pmem_read, pmem_write}, 128'd0);
    chk("rst_mid.after_resp", {126'd0, i_resp, d_resp}, 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
